// File: rtl/encoder_pkg.sv
// Shared defaults and FSM encoding for the encoder input filter.
package encoder_pkg;

  localparam int FILT_W_DEF = 8;
  localparam int ERR_W_DEF  = 16;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/encoder_input_filter_if.sv
// Pin-side and status signals of the encoder input filter.
interface encoder_input_filter_if
  import encoder_pkg::*;
#(
  parameter int FILT_W = FILT_W_DEF,
  parameter int ERR_W  = ERR_W_DEF
);

  logic              enc_a_raw;
  logic              enc_b_raw;
  logic              filt_en;
  logic [FILT_W-1:0] filt_len;
  logic              err_clr;
  logic              ENC_A;
  logic              ENC_B;
  logic              READY;
  logic              ERR_PULSE;
  logic [ERR_W-1:0]  ERR_COUNT;

  modport master (
    output enc_a_raw, enc_b_raw, filt_en, filt_len, err_clr,
    input  ENC_A, ENC_B, READY, ERR_PULSE, ERR_COUNT
  );

  modport slave (
    input  enc_a_raw, enc_b_raw, filt_en, filt_len, err_clr,
    output ENC_A, ENC_B, READY, ERR_PULSE, ERR_COUNT
  );

endinterface

// File: rtl/enc_chan_filter.sv
// One quadrature channel: synchronizer, stable-count glitch filter, output flop.
module enc_chan_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              raw,
  input  logic              run,
  input  logic              load,
  input  logic              filt_en,
  input  logic [FILT_W-1:0] filt_len,
  output logic              OUT
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("enc_chan_filter: SYNC_STAGES must be 2..4");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_n;
  logic [FILT_W-1:0]      cnt;
  logic [FILT_W-1:0]      len_eff;
  logic [FILT_W:0]        cnt_inc;
  logic                   hit;

  assign s_n     = sync_q[SYNC_STAGES-1];
  // A programmed length of 0 behaves like 1 (no filtering beyond one sample).
  assign len_eff = (filt_len == '0) ? FILT_W'(1) : filt_len;
  // One extra bit so the increment can never wrap before the compare.
  assign cnt_inc = {1'b0, cnt} + (FILT_W+1)'(1);
  // >= rather than == so lowering filt_len mid-count still releases the level.
  assign hit     = (cnt_inc >= {1'b0, len_eff});

  // Metastability chain from the asynchronous pin.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  // Output follows the synchronized level only after it has been stable long enough.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      OUT <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      OUT <= s_n;
      cnt <= '0;
    end else if (run) begin
      if (!filt_en) begin
        OUT <= s_n;
        cnt <= '0;
      end else if (s_n == OUT) begin
        cnt <= '0;
      end else if (hit) begin
        OUT <= s_n;
        cnt <= '0;
      end else begin
        cnt <= cnt_inc[FILT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/encoder_input_filter.sv
// Quadrature input conditioning with illegal-transition detection.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | synchronizers filling; outputs loaded on last cycle, READY set
// ST_RUN  | filtering and illegal-transition detection active until reset
module encoder_input_filter
  import encoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = FILT_W_DEF,
  parameter int ERR_W       = ERR_W_DEF
) (
  input logic                    aclk,
  input logic                    aresetn,
  encoder_input_filter_if.slave  bus
);

  logic [0:0]       state;
  logic [2:0]       init_cnt;
  logic             load;
  logic             run;
  logic             enc_a;
  logic             enc_b;
  logic             prev_a;
  logic             prev_b;
  logic             arm;
  logic             err_det;
  logic             err_pulse;
  logic             ready;
  logic [ERR_W-1:0] err_count;

  assign load = (state == ST_INIT) && (init_cnt == 3'(SYNC_STAGES));
  assign run  = (state == ST_RUN);

  enc_chan_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_chan_a (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .raw      (bus.enc_a_raw),
    .run      (run),
    .load     (load),
    .filt_en  (bus.filt_en),
    .filt_len (bus.filt_len),
    .OUT      (enc_a)
  );

  enc_chan_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_chan_b (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .raw      (bus.enc_b_raw),
    .run      (run),
    .load     (load),
    .filt_en  (bus.filt_en),
    .filt_len (bus.filt_len),
    .OUT      (enc_b)
  );

  // INIT waits for the synchronizers to fill, then hands over to RUN for good.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      ready    <= 1'b0;
    end else if (state == ST_INIT) begin
      if (load) begin
        state <= ST_RUN;
        ready <= 1'b1;
      end else begin
        init_cnt <= init_cnt + 3'd1;
      end
    end
  end

  // arm is set only once the outputs have been driven by RUN logic, so the
  // INIT load edge is never seen as a transition.
  assign err_det = arm && (enc_a != prev_a) && (enc_b != prev_b);

  // Track previous outputs and flag both channels moving on the same edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      prev_a    <= 1'b0;
      prev_b    <= 1'b0;
      arm       <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      prev_a    <= enc_a;
      prev_b    <= enc_b;
      arm       <= run;
      err_pulse <= err_det;
    end
  end

  // Saturating diagnostic counter; a clear colliding with an event keeps the event.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_count <= '0;
    end else if (bus.err_clr) begin
      err_count <= err_det ? ERR_W'(1) : '0;
    end else if (err_det && (err_count != '1)) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

  assign bus.ENC_A     = enc_a;
  assign bus.ENC_B     = enc_b;
  assign bus.READY     = ready;
  assign bus.ERR_PULSE = err_pulse;
  assign bus.ERR_COUNT = err_count;

endmodule

// File: tb/tb_encoder_input_filter.sv
// Directed bench for encoder_input_filter (SYNC_STAGES=2, FILT_W=8, ERR_W=16).
module tb_encoder_input_filter;

  localparam int SYNC_STAGES = 2;
  localparam int FILT_W      = 8;
  localparam int ERR_W       = 16;

  logic aclk;
  logic aresetn;
  int   checks;
  int   errors;

  encoder_input_filter_if #(.FILT_W(FILT_W), .ERR_W(ERR_W)) bus ();

  encoder_input_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W),
    .ERR_W       (ERR_W)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset;
    aresetn       = 1'b0;
    bus.enc_a_raw = 1'b1;
    bus.enc_b_raw = 1'b1;
    bus.filt_en   = 1'b1;
    bus.filt_len  = 8'd8;
    bus.err_clr   = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.READY !== 1'b0 || bus.ENC_A !== 1'b0 || bus.ENC_B !== 1'b0 ||
        bus.ERR_PULSE !== 1'b0 || bus.ERR_COUNT !== 16'h0) begin
      errors++;
      $display("FAIL reset_values: got ready=%b a=%b b=%b pulse=%b cnt=%0h, want 0 0 0 0 0",
               bus.READY, bus.ENC_A, bus.ENC_B, bus.ERR_PULSE, bus.ERR_COUNT);
    end
    aresetn = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.READY !== 1'b0) begin
      errors++;
      $display("FAIL ready_early: got %b want 0 after 2 edges", bus.READY);
    end
    tick();
    checks++;
    if (bus.READY !== 1'b1 || bus.ENC_A !== 1'b1 || bus.ENC_B !== 1'b1) begin
      errors++;
      $display("FAIL init_load: got ready=%b a=%b b=%b want 1 1 1",
               bus.READY, bus.ENC_A, bus.ENC_B);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.ERR_PULSE !== 1'b0) begin
        errors++;
        $display("FAIL init_no_pulse[%0d]: got %b want 0", i, bus.ERR_PULSE);
      end
      tick();
    end
    checks++;
    if (bus.ERR_COUNT !== 16'h0) begin
      errors++;
      $display("FAIL init_count: got %0h want 0", bus.ERR_COUNT);
    end
  endtask

  task automatic test_latency_glitch;
    bus.enc_a_raw = 1'b0;
    repeat (15) tick();
    bus.enc_b_raw = 1'b0;
    repeat (15) tick();
    checks++;
    if (bus.ENC_A !== 1'b0 || bus.ENC_B !== 1'b0) begin
      errors++;
      $display("FAIL settle_low: got a=%b b=%b want 0 0", bus.ENC_A, bus.ENC_B);
    end
    bus.filt_len = 8'd4;
    repeat (3) tick();
    // 3-cycle glitch must be swallowed.
    bus.enc_a_raw = 1'b1;
    for (int e = 0; e < 12; e++) begin
      if (e == 3) bus.enc_a_raw = 1'b0;
      tick();
      checks++;
      if (bus.ENC_A !== 1'b0) begin
        errors++;
        $display("FAIL glitch_edge%0d: got %b want 0", e, bus.ENC_A);
      end
    end
    // 4-cycle level passes: rises at edge 5, falls at edge 9.
    bus.enc_a_raw = 1'b1;
    for (int e = 0; e < 12; e++) begin
      logic exp_a;
      if (e == 4) bus.enc_a_raw = 1'b0;
      tick();
      exp_a = (e >= 5 && e <= 8);
      checks++;
      if (bus.ENC_A !== exp_a) begin
        errors++;
        $display("FAIL level_edge%0d: got %b want %b", e, bus.ENC_A, exp_a);
      end
    end
  endtask

  task automatic test_bypass;
    logic hist [0:31];
    bus.filt_en = 1'b0;
    repeat (3) tick();
    for (int e = 0; e < 30; e++) begin
      logic exp_b;
      hist[e] = ((e / 3) % 2) == 1;
      bus.enc_b_raw = hist[e];
      tick();
      exp_b = (e >= 2) ? hist[e-2] : 1'b0;
      checks++;
      if (bus.ENC_B !== exp_b || bus.ENC_A !== 1'b0 || bus.ERR_PULSE !== 1'b0) begin
        errors++;
        $display("FAIL bypass_edge%0d: got b=%b a=%b pulse=%b want b=%b a=0 pulse=0",
                 e, bus.ENC_B, bus.ENC_A, bus.ERR_PULSE, exp_b);
      end
    end
    bus.enc_b_raw = 1'b0;
    repeat (4) tick();
    bus.filt_en = 1'b1;
  endtask

  task automatic test_illegal;
    bus.filt_len = 8'd2;
    repeat (4) tick();
    checks++;
    if (bus.ERR_COUNT !== 16'h0 || bus.ENC_A !== 1'b0 || bus.ENC_B !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pre: got cnt=%0h a=%b b=%b want 0 0 0",
               bus.ERR_COUNT, bus.ENC_A, bus.ENC_B);
    end
    bus.enc_a_raw = 1'b1;
    bus.enc_b_raw = 1'b1;
    for (int e = 0; e < 8; e++) begin
      logic exp_ab, exp_p;
      logic [15:0] exp_c;
      tick();
      exp_ab = (e >= 3);
      exp_p  = (e == 4);
      exp_c  = (e >= 4) ? 16'd1 : 16'd0;
      checks++;
      if (bus.ENC_A !== exp_ab || bus.ENC_B !== exp_ab ||
          bus.ERR_PULSE !== exp_p || bus.ERR_COUNT !== exp_c) begin
        errors++;
        $display("FAIL illegal_edge%0d: got a=%b b=%b p=%b c=%0h want a=%b b=%b p=%b c=%0h",
                 e, bus.ENC_A, bus.ENC_B, bus.ERR_PULSE, bus.ERR_COUNT,
                 exp_ab, exp_ab, exp_p, exp_c);
      end
    end
  endtask

  task automatic test_clear_collision;
    bus.enc_a_raw = 1'b0;
    bus.enc_b_raw = 1'b0;
    for (int e = 0; e < 7; e++) begin
      logic exp_p;
      if (e == 4) bus.err_clr = 1'b1;
      if (e == 5) bus.err_clr = 1'b0;
      tick();
      exp_p = (e == 4);
      checks++;
      if (bus.ERR_COUNT !== 16'd1 || bus.ERR_PULSE !== exp_p) begin
        errors++;
        $display("FAIL clr_collide_edge%0d: got c=%0h p=%b want c=1 p=%b",
                 e, bus.ERR_COUNT, bus.ERR_PULSE, exp_p);
      end
    end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    checks++;
    if (bus.ERR_COUNT !== 16'h0) begin
      errors++;
      $display("FAIL clr_plain: got %0h want 0", bus.ERR_COUNT);
    end
  endtask

  task automatic test_saturation;
    bus.filt_en = 1'b0;
    repeat (3) tick();
    for (int e = 0; e < 10; e++) begin
      bus.enc_a_raw = ~bus.enc_a_raw;
      bus.enc_b_raw = ~bus.enc_b_raw;
      tick();
    end
    repeat (4) tick();
    checks++;
    if (bus.ERR_COUNT !== 16'd10) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d want 10", bus.ERR_COUNT);
    end
    for (int e = 0; e < 70000; e++) begin
      bus.enc_a_raw = ~bus.enc_a_raw;
      bus.enc_b_raw = ~bus.enc_b_raw;
      tick();
      if (e == 100) begin
        checks++;
        if (bus.ERR_PULSE !== 1'b1) begin
          errors++;
          $display("FAIL sat_pulse_active: got %b want 1", bus.ERR_PULSE);
        end
      end
    end
    repeat (4) tick();
    checks++;
    if (bus.ERR_COUNT !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturate: got %0h want ffff", bus.ERR_COUNT);
    end
    repeat (10) tick();
    checks++;
    if (bus.ERR_COUNT !== 16'hFFFF || bus.ERR_PULSE !== 1'b0) begin
      errors++;
      $display("FAIL saturate_hold: got c=%0h p=%b want c=ffff p=0",
               bus.ERR_COUNT, bus.ERR_PULSE);
    end
    bus.filt_en = 1'b1;
  endtask

  task automatic test_reset_mid_count;
    bus.filt_len  = 8'd200;
    bus.enc_a_raw = 1'b1;
    repeat (100) tick();
    checks++;
    if (bus.ENC_A !== 1'b0 || bus.ERR_COUNT !== 16'hFFFF || bus.READY !== 1'b1) begin
      errors++;
      $display("FAIL midcount_pre: got a=%b c=%0h ready=%b want a=0 c=ffff ready=1",
               bus.ENC_A, bus.ERR_COUNT, bus.READY);
    end
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if (bus.ENC_A !== 1'b0 || bus.ENC_B !== 1'b0 || bus.READY !== 1'b0 ||
        bus.ERR_PULSE !== 1'b0 || bus.ERR_COUNT !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: got a=%b b=%b ready=%b p=%b c=%0h want all 0",
               bus.ENC_A, bus.ENC_B, bus.READY, bus.ERR_PULSE, bus.ERR_COUNT);
    end
    repeat (2) tick();
    aresetn = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.READY !== 1'b1 || bus.ENC_A !== 1'b1 || bus.ENC_B !== 1'b0) begin
      errors++;
      $display("FAIL reinit_load: got ready=%b a=%b b=%b want 1 1 0",
               bus.READY, bus.ENC_A, bus.ENC_B);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.ERR_PULSE !== 1'b0 || bus.ERR_COUNT !== 16'h0) begin
        errors++;
        $display("FAIL reinit_no_err[%0d]: got p=%b c=%0h want 0 0",
                 i, bus.ERR_PULSE, bus.ERR_COUNT);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_latency_glitch();
    test_bypass();
    test_illegal();
    test_clear_collision();
    test_saturation();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_input_filter.md
# encoder_input_filter

- Conditions the raw quadrature inputs before they reach the encoder peripheral.
- Each channel gets a synchronizer and a programmable stable-count glitch filter.
- Filtered ENC_A/ENC_B feed the encoder's enc_a/enc_b inputs directly.
- The block also flags illegal quadrature transitions (both channels changing in the same cycle) and keeps a saturating error count for software diagnostics.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flop depth per channel; legal range 2..4.
- FILT_W, 8: width of filter length and stable counter.
- ERR_W, 16: width of error counter.

Ports:
- aclk  in  1  system clock, all logic on rising edge.
- aresetn  in  1  one clock; reset is asynchronous and active-low.
- enc_a_raw  in  1  raw channel A from pin, asynchronous.
- enc_b_raw  in  1  raw channel B from pin, asynchronous.
- filt_en  in  1  1 = filter active; 0 = bypass, output follows synchronized value.
- filt_len  in  FILT_W  consecutive cycles a new level must persist; 0 treated as 1; sampled every cycle.
- err_clr  in  1  single-cycle pulse, clears ERR_COUNT.
- ENC_A  out  1  filtered channel A.
- ENC_B  out  1  filtered channel B.
- READY  out  1  high once initialization completes; filtered outputs are meaningful.
- ERR_PULSE  out  1  one-cycle pulse per illegal transition.
- ERR_COUNT  out  ERR_W  saturating count of illegal transitions.

## Operation
- **Synchronizer:** a SYNC_STAGES-deep flop chain per channel. The last stage is sN_a/sN_b.
- **State machine, INIT:**
  - Entered on reset.
  - An init counter runs SYNC_STAGES cycles.
  - On the final INIT cycle, load ENC_A<=sN_a, ENC_B<=sN_b, set READY, and go to RUN.
  - No error detection in INIT or on the load edge.
- **State machine, RUN:** the filter and error detection are active. RUN never exits except on reset.
- **Filter, per channel, in RUN:**
  - If filt_en=0: out<=sN and cnt<=0 every cycle.
  - Else if sN==out: cnt<=0.
  - Else if cnt+1 >= max(filt_len,1): out<=sN and cnt<=0.
  - Else: cnt<=cnt+1.
  - The >= compare keeps behaviour correct if filt_len is lowered mid-count.
  - cnt never exceeds 2^FILT_W-1.
- **Illegal transition:**
  - Detected in RUN when ENC_A and ENC_B both change on the same edge.
  - ERR_PULSE is high the following cycle.
  - ERR_COUNT increments in the same cycle as ERR_PULSE.
  - ERR_COUNT saturates at all-ones.
- **err_clr:**
  - Sets ERR_COUNT to 0.
  - If coincident with an increment, ERR_COUNT<=1; the event is not lost.
- Single-channel changes are legal.

## Timing
- **Reset values:** ENC_A=0, ENC_B=0, READY=0, ERR_PULSE=0, ERR_COUNT=0. All sync flops, cnt and the init counter are 0. State is INIT.
- **Reset timing:**
  - Asserting aresetn low at any time clears all state immediately, including mid-count.
  - READY rises SYNC_STAGES+1 edges after aresetn deassertion.
- **Latency, filter on:**
  - A raw input change set up before edge 0 appears at sN after edge SYNC_STAGES-1.
  - ENC_x updates at edge SYNC_STAGES-1+max(filt_len,1).
  - This totals SYNC_STAGES+max(filt_len,1)-1 edges after edge 0, e.g. 9 edges for SYNC_STAGES=2, filt_len=8.
- **Latency, bypass:** ENC_x updates at edge SYNC_STAGES.
- **Glitch rejection:** any pulse shorter than max(filt_len,1) cycles at sN is suppressed. cnt restarts from 0 on every return to the output level.
- **ERR_PULSE:** exactly one cycle wide. It is registered from the ENC_A/ENC_B change edge, so it appears 1 cycle after the change.

## Structure
- Package encoder_pkg holds:
  - FILT_W default
  - ERR_W default
  - INIT/RUN state encoding, localparam 1-bit
- Sub-module enc_chan_filter contains the synchronizer, stable counter and output flop for one channel.
  - Ports: aclk, aresetn, raw, run, load, filt_en, filt_len, OUT.
  - Instantiated twice.
- The top level holds the INIT/RUN state machine, init counter, edge compare and error counter.

## Test plan
- **Reset init:** enc_a_raw=1, enc_b_raw=1 held through reset release, filt_len=8 -> READY rises 3 edges after release, ENC_A=ENC_B=1 at that edge, ERR_PULSE never asserts, ERR_COUNT=0.
- **Latency and glitch:**
  - filt_len=4: a 3-cycle high glitch on enc_a_raw -> ENC_A stays 0.
  - A 4-cycle high level -> ENC_A rises exactly 5 edges after the raw edge.
- **Bypass:** filt_en=0, toggle enc_b_raw every 3 cycles -> ENC_B follows with 2-edge latency, no pulse lost.
- **Illegal transition:** from A=0,B=0, raise both raw inputs on the same edge, filt_len=2 -> ENC_A and ENC_B change on the same edge, ERR_PULSE high one cycle, ERR_COUNT=1.
- **Clear collision and saturation:**
  - Assert err_clr coincident with an increment -> ERR_COUNT=1.
  - Force 70000 illegal events with ERR_W=16 -> ERR_COUNT=16'hFFFF and stays there.
- **Reset mid-count:**
  - filt_len=200, change enc_a_raw, pull aresetn low after 100 cycles -> all outputs 0 immediately.
  - After release, ENC_A loads the current raw level via INIT without an error.
